// File: rtl/mac_seq.sv
// Vector sequencer around a combinational MAC: element-wise add/multiply or dot product
// over len operand pairs, with valid/ready streams on both sides.
module mac_seq #(
    parameter int unsigned bw    = 8,
    parameter int unsigned LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       cmd,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [bw-1:0]    in_a,
    input  logic [bw-1:0]    in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [bw-1:0]    out_data,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam logic [1:0] MacAdd = 2'b00;
    localparam logic [1:0] MacFma = 2'b01;
    localparam logic [1:0] MacMul = 2'b10;

    logic [1:0]       state_q, state_d;
    logic             dot_q, dot_d;
    logic             mul_q, mul_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [bw-1:0]    acc_q, acc_d;
    logic [bw-1:0]    out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;

    logic [1:0]       mac_mode;
    logic [bw-1:0]    mac_prod;
    logic [bw-1:0]    mac_res;

    logic             accept;
    logic             out_xfer;
    logic             last;

    // Combinational MAC datapath; all results wrap modulo 2^bw.
    assign mac_mode = dot_q ? MacFma : (mul_q ? MacMul : MacAdd);

    always_comb begin
        mac_prod = in_a * in_b;
        case (mac_mode)
            2'b00:   mac_res = in_a + in_b;
            2'b01:   mac_res = mac_prod + acc_q;
            default: mac_res = mac_prod;
        endcase
    end

    // Dot mode never holds a result in RUN, so it can always take a pair.
    assign in_ready = (state_q == StRun) && (dot_q || !out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign out_xfer = out_valid_q && out_ready;
    assign last     = (cnt_q == LEN_W'(1));

    always_comb begin
        state_d     = state_q;
        dot_d       = dot_q;
        mul_d       = mul_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    dot_d = (cmd == 2'b01);
                    mul_d = cmd[1];
                    cnt_d = len;
                    acc_d = '0;
                    if (len == '0) begin
                        if (cmd == 2'b01) begin
                            out_data_d  = '0;
                            out_valid_d = 1'b1;
                            state_d     = StDrain;
                        end else begin
                            state_d = StDone;
                        end
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (dot_q) begin
                    if (accept) begin
                        acc_d = mac_res;
                        cnt_d = cnt_q - LEN_W'(1);
                        if (last) begin
                            out_data_d  = mac_res;
                            out_valid_d = 1'b1;
                            state_d     = StDrain;
                        end
                    end
                end else if (accept) begin
                    // New result replaces one leaving this cycle, no bubble.
                    out_data_d  = mac_res;
                    out_valid_d = 1'b1;
                    cnt_d       = cnt_q - LEN_W'(1);
                    if (last) begin
                        state_d = StDrain;
                    end
                end else if (out_xfer) begin
                    out_valid_d = 1'b0;
                end
            end
            StDrain: begin
                if (!out_valid_q || out_xfer) begin
                    out_valid_d = 1'b0;
                    state_d     = StDone;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            dot_q       <= 1'b0;
            mul_q       <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dot_q       <= dot_d;
            mul_q       <= mul_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);

endmodule

// File: tb/tb_mac_seq.sv
// Directed bench for mac_seq: hand-computed vectors, checked one step at a time
// with immediate assertions just after each rising edge.
module tb_mac_seq;

    localparam int unsigned BW    = 8;
    localparam int unsigned LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [1:0]       cmd;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [BW-1:0]    in_a;
    logic [BW-1:0]    in_b;
    logic             out_valid;
    logic             out_ready;
    logic [BW-1:0]    out_data;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;
    int xfers  = 0;
    int mark;

    always #5 clk = ~clk;

    mac_seq #(
        .bw   (BW),
        .LEN_W(LEN_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cmd      (cmd),
        .len      (len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy),
        .done     (done)
    );

    // Independent count of output handshakes, used to catch lost/duplicated results.
    always @(posedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) xfers <= xfers + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cmd_start(input logic [1:0] c, input logic [LEN_W-1:0] n);
        start = 1'b1;
        cmd   = c;
        len   = n;
        tick();
        start = 1'b0;
    endtask

    task automatic pair(input logic [BW-1:0] a, input logic [BW-1:0] b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        cmd       = 2'b00;
        len       = '0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        rst = 1'b0;
        tick();

        // Dot product (2,3),(4,5),(1,7) -> 33; a stray start in RUN must be ignored.
        mark = xfers;
        cmd_start(2'b01, 4'd3);
        chk("dot_busy", 32'(busy), 1);
        chk("dot_in_ready", 32'(in_ready), 1);
        pair(8'd2, 8'd3);
        start = 1'b1;
        cmd   = 2'b00;
        len   = 4'd0;
        tick();
        start = 1'b0;
        chk("dot_no_out_mid", 32'(out_valid), 0);
        pair(8'd4, 8'd5);
        tick();
        chk("dot_no_out_mid2", 32'(out_valid), 0);
        pair(8'd1, 8'd7);
        tick();
        in_valid = 1'b0;
        chk("dot_out_valid", 32'(out_valid), 1);
        chk("dot_out_data", 32'(out_data), 33);
        chk("dot_drain_in_ready", 32'(in_ready), 0);
        chk("dot_no_done_early", 32'(done), 0);
        tick();
        chk("dot_done", 32'(done), 1);
        chk("dot_done_busy", 32'(busy), 1);
        chk("dot_out_cleared", 32'(out_valid), 0);
        tick();
        chk("dot_idle_done", 32'(done), 0);
        chk("dot_idle_busy", 32'(busy), 0);
        chk("dot_xfers", 32'(xfers - mark), 1);

        // Element add, back-to-back: 4,3,7,128.
        mark = xfers;
        cmd_start(2'b00, 4'd4);
        pair(8'd250, 8'd10);
        chk("add_in_ready0", 32'(in_ready), 1);
        tick();
        chk("add_out0_valid", 32'(out_valid), 1);
        chk("add_out0", 32'(out_data), 4);
        chk("add_in_ready1", 32'(in_ready), 1);
        pair(8'd1, 8'd2);
        tick();
        chk("add_out1", 32'(out_data), 3);
        chk("add_in_ready2", 32'(in_ready), 1);
        pair(8'd3, 8'd4);
        tick();
        chk("add_out2", 32'(out_data), 7);
        pair(8'd127, 8'd1);
        tick();
        in_valid = 1'b0;
        chk("add_out3", 32'(out_data), 128);
        chk("add_out3_valid", 32'(out_valid), 1);
        chk("add_drain_in_ready", 32'(in_ready), 0);
        tick();
        chk("add_done", 32'(done), 1);
        tick();
        chk("add_idle", 32'(busy), 0);
        chk("add_xfers", 32'(xfers - mark), 4);

        // Element multiply with out_ready 1,0,0,1: (16,16)->0, (3,5)->15.
        mark = xfers;
        cmd_start(2'b10, 4'd2);
        out_ready = 1'b1;
        pair(8'd16, 8'd16);
        tick();
        chk("mul_out0_valid", 32'(out_valid), 1);
        chk("mul_out0", 32'(out_data), 0);
        out_ready = 1'b0;
        pair(8'd3, 8'd5);
        #1;
        chk("mul_stall_in_ready", 32'(in_ready), 0);
        tick();
        chk("mul_hold_data", 32'(out_data), 0);
        chk("mul_hold_valid", 32'(out_valid), 1);
        chk("mul_hold_in_ready", 32'(in_ready), 0);
        tick();
        chk("mul_hold_data2", 32'(out_data), 0);
        out_ready = 1'b1;
        #1;
        chk("mul_resume_in_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        chk("mul_out1", 32'(out_data), 15);
        chk("mul_out1_valid", 32'(out_valid), 1);
        chk("mul_drain_in_ready", 32'(in_ready), 0);
        tick();
        chk("mul_done", 32'(done), 1);
        tick();
        chk("mul_xfers", 32'(xfers - mark), 2);

        // Dot wrap: 200*2 + 100*1 = 500 mod 256 = 244.
        cmd_start(2'b01, 4'd2);
        pair(8'd200, 8'd2);
        tick();
        pair(8'd100, 8'd1);
        tick();
        in_valid = 1'b0;
        chk("wrap_out", 32'(out_data), 244);
        chk("wrap_valid", 32'(out_valid), 1);
        tick();
        chk("wrap_done", 32'(done), 1);
        tick();

        // len=0 dot: single zero result, then done.
        mark = xfers;
        cmd_start(2'b01, 4'd0);
        chk("len0_dot_valid", 32'(out_valid), 1);
        chk("len0_dot_data", 32'(out_data), 0);
        chk("len0_dot_in_ready", 32'(in_ready), 0);
        tick();
        chk("len0_dot_done", 32'(done), 1);
        tick();
        chk("len0_dot_idle", 32'(busy), 0);
        chk("len0_dot_xfers", 32'(xfers - mark), 1);

        // len=0 add: no output, straight to the done pulse.
        mark = xfers;
        cmd_start(2'b00, 4'd0);
        chk("len0_add_valid", 32'(out_valid), 0);
        chk("len0_add_done", 32'(done), 1);
        tick();
        chk("len0_add_done_off", 32'(done), 0);
        chk("len0_add_idle", 32'(busy), 0);
        chk("len0_add_xfers", 32'(xfers - mark), 0);

        // Reset after 2 of 5 dot accepts, then a fresh len=1 dot of (6,7) -> 42.
        cmd_start(2'b01, 4'd5);
        pair(8'd9, 8'd9);
        tick();
        pair(8'd5, 8'd5);
        tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_in_ready", 32'(in_ready), 0);
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_out_data", 32'(out_data), 0);
        chk("mid_rst_done", 32'(done), 0);
        tick();
        chk("mid_rst_no_done", 32'(done), 0);
        cmd_start(2'b01, 4'd1);
        pair(8'd6, 8'd7);
        tick();
        in_valid = 1'b0;
        chk("post_rst_out", 32'(out_data), 42);
        chk("post_rst_valid", 32'(out_valid), 1);
        tick();
        chk("post_rst_done", 32'(done), 1);
        tick();
        chk("post_rst_idle", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
